// File: rtl/sound_pkg.sv
// Shared types and default timing constants for the sound player.
// Also provides the trigger classifier and a range check used at elaboration.
package sound_pkg;

  typedef enum logic [1:0] {SND_NONE, SND_MOVE, SND_GOOD, SND_BAD} sound_e;
  typedef enum logic [1:0] {IDLE, NOTE1, GAP, NOTE2} player_state_e;

  localparam int DEF_CNT_W     = 16;
  localparam int DEF_HALF_GOOD = 5682;
  localparam int DEF_HALF_BAD1 = 7576;
  localparam int DEF_HALF_BAD2 = 11364;
  localparam int DEF_HALF_MOVE = 3788;
  localparam int DEF_NOTE_LEN  = 50000;
  localparam int DEF_GAP_LEN   = 10000;

  // Priority: bad collision, then good collision, then any move direction.
  function automatic sound_e classify(input logic bad, input logic good, input logic [3:0] dir);
    if (bad)       return SND_BAD;
    else if (good) return SND_GOOD;
    else if (|dir) return SND_MOVE;
    else           return SND_NONE;
  endfunction

  function automatic bit fits_cnt(input int value, input int width);
    return (value >= 2) && (longint'(value) < (longint'(1) << width));
  endfunction

endpackage

// File: rtl/sound_player_tone_gen.sv
// Square-wave divider: the output toggles every `half` enabled cycles.
// A clear forces the divider and output low so every note starts on a low phase.
module tone_gen
  import sound_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic [CNT_W-1:0] half,
  output logic             wave
);

  logic [CNT_W-1:0] div_q;
  logic             wave_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q  <= '0;
      wave_q <= 1'b0;
    end else if (clear) begin
      div_q  <= '0;
      wave_q <= 1'b0;
    end else if (en) begin
      if (div_q == half - CNT_W'(1)) begin
        div_q  <= '0;
        wave_q <= ~wave_q;
      end else begin
        div_q <= div_q + CNT_W'(1);
      end
    end
  end

  assign wave = wave_q;

endmodule

// File: rtl/sound_player.sv
// Turns a sound trigger into a timed square-wave effect (move click, good tone,
// or two-note bad sequence); owns the trigger edge detect, FSM and duration counter.
module sound_player
  import sound_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int HALF_GOOD = DEF_HALF_GOOD,
  parameter int HALF_BAD1 = DEF_HALF_BAD1,
  parameter int HALF_BAD2 = DEF_HALF_BAD2,
  parameter int HALF_MOVE = DEF_HALF_MOVE,
  parameter int NOTE_LEN  = DEF_NOTE_LEN,
  parameter int GAP_LEN   = DEF_GAP_LEN
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       playSound,
  input  logic       mode_i,
  input  logic       goodColl,
  input  logic       badColl,
  input  logic [3:0] direction,
  output logic       speaker,
  output logic       busy,
  output sound_e     soundId
);

  if (!fits_cnt(HALF_GOOD, CNT_W) || !fits_cnt(HALF_BAD1, CNT_W) || !fits_cnt(HALF_BAD2, CNT_W) ||
      !fits_cnt(HALF_MOVE, CNT_W) || !fits_cnt(NOTE_LEN, CNT_W)) begin : g_param_check
    $error("sound_player: a HALF_* or NOTE_LEN value is outside [2, 2**CNT_W)");
  end

  localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_LEN - 1);
  localparam logic [CNT_W-1:0] MOVE_LAST = CNT_W'((NOTE_LEN >> 2) - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_LEN - 1);

  player_state_e    state_q, state_d;
  sound_e           cls_q, cls_d;
  logic [CNT_W-1:0] dur_q, dur_d;
  logic             busy_q, busy_d;
  logic             playSound_q;

  logic             trig;
  sound_e           trig_cls;
  logic             dur_done;
  logic             restart;
  logic             tone_clear;
  logic             tone_en;
  logic [CNT_W-1:0] half_sel;

  assign trig     = playSound & ~playSound_q & mode_i;
  assign trig_cls = classify(badColl, goodColl, direction);

  always_comb begin
    if (state_q == GAP)          dur_done = (dur_q == GAP_LAST);
    else if (cls_q == SND_MOVE)  dur_done = (dur_q == MOVE_LAST);
    else                         dur_done = (dur_q == NOTE_LAST);
  end

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    restart = 1'b0;
    unique case (state_q)
      IDLE:  if (trig && trig_cls != SND_NONE) begin
               state_d = NOTE1;
               cls_d   = trig_cls;
             end
      NOTE1: if (dur_done) state_d = (cls_q == SND_BAD) ? GAP : IDLE;
      GAP:   if (dur_done) state_d = NOTE2;
      NOTE2: if (dur_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A bad collision always wins over whatever is playing, including another bad effect.
    if (state_q != IDLE && trig && trig_cls == SND_BAD) begin
      state_d = NOTE1;
      cls_d   = SND_BAD;
      restart = 1'b1;
    end
    if (state_q != IDLE && !mode_i) begin
      state_d = IDLE;
    end
    if (state_d == IDLE) cls_d = SND_NONE;
    dur_d  = (state_d != state_q || restart || state_d == IDLE) ? '0 : dur_q + CNT_W'(1);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cls_q       <= SND_NONE;
      dur_q       <= '0;
      busy_q      <= 1'b0;
      playSound_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cls_q       <= cls_d;
      dur_q       <= dur_d;
      busy_q      <= busy_d;
      playSound_q <= playSound;
    end
  end

  // The tone is cleared on every state change so each note begins low with a fresh divider.
  assign tone_en    = (state_q == NOTE1) || (state_q == NOTE2);
  assign tone_clear = (state_d != state_q) || restart || !((state_d == NOTE1) || (state_d == NOTE2));

  always_comb begin
    unique case (cls_q)
      SND_BAD:  half_sel = (state_q == NOTE2) ? CNT_W'(HALF_BAD2) : CNT_W'(HALF_BAD1);
      SND_GOOD: half_sel = CNT_W'(HALF_GOOD);
      default:  half_sel = CNT_W'(HALF_MOVE);
    endcase
  end

  tone_gen #(.CNT_W(CNT_W)) u_tone (
    .clk   (clk),
    .rst   (rst),
    .clear (tone_clear),
    .en    (tone_en),
    .half  (half_sel),
    .wave  (speaker)
  );

  assign busy    = busy_q;
  assign soundId = cls_q;

endmodule

// File: tb/tb_sound_player.sv
// Directed bench: stimulus queues the expected per-cycle outputs, a monitor compares them at negedge.
module tb_sound_player;
  import sound_pkg::*;

  typedef struct packed {
    logic       busy;
    logic       spk;
    logic [1:0] id;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       playSound = 1'b0;
  logic       mode_i = 1'b1;
  logic       goodColl = 1'b0;
  logic       badColl = 1'b0;
  logic [3:0] direction = 4'b0000;
  logic       speaker;
  logic       busy;
  sound_e     soundId;

  exp_t  plan[$];
  exp_t  sb[$];
  string tag_q[$];
  string cur_tag = "init";
  int    n_tests = 0;
  int    n_fail  = 0;

  always #5 clk = ~clk;

  sound_player #(
    .CNT_W(16), .HALF_GOOD(4), .HALF_BAD1(3), .HALF_BAD2(6),
    .HALF_MOVE(2), .NOTE_LEN(40), .GAP_LEN(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .playSound (playSound),
    .mode_i    (mode_i),
    .goodColl  (goodColl),
    .badColl   (badColl),
    .direction (direction),
    .speaker   (speaker),
    .busy      (busy),
    .soundId   (soundId)
  );

  task automatic plan_idle(input int n);
    exp_t e;
    e.busy = 1'b0; e.spk = 1'b0; e.id = 2'(SND_NONE);
    repeat (n) plan.push_back(e);
  endtask

  // Speaker at cycle k of a note is (k / half) mod 2: first rise after half cycles.
  task automatic plan_note(input sound_e id, input int half, input int len);
    exp_t e;
    for (int k = 0; k < len; k++) begin
      e.busy = 1'b1;
      e.spk  = 1'((k / half) % 2);
      e.id   = 2'(id);
      plan.push_back(e);
    end
  endtask

  task automatic plan_gap(input int len);
    exp_t e;
    e.busy = 1'b1; e.spk = 1'b0; e.id = 2'(SND_BAD);
    repeat (len) plan.push_back(e);
  endtask

  task automatic run(input int n);
    exp_t e;
    repeat (n) begin
      if (plan.size() > 0) e = plan.pop_front();
      else begin
        e.busy = 1'b0; e.spk = 1'b0; e.id = 2'(SND_NONE);
      end
      sb.push_back(e);
      tag_q.push_back(cur_tag);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin : monitor
    exp_t  e;
    string t;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        t = tag_q.pop_front();
        n_tests++;
        if ({busy, speaker, 2'(soundId)} !== e) begin
          n_fail++;
          $display("FAIL %s @%0t: got busy=%0b speaker=%0b soundId=%0d, expected busy=%0b speaker=%0b soundId=%0d",
                   t, $time, busy, speaker, soundId, e.busy, e.spk, e.id);
        end
      end
    end
  end

  initial begin : stimulus
    @(posedge clk);
    #1;
    cur_tag = "reset";
    run(2);
    rst = 1'b0;
    run(3);

    cur_tag = "good";
    goodColl = 1'b1; playSound = 1'b1;
    plan_idle(1); plan_note(SND_GOOD, 4, 40);
    run(3);
    playSound = 1'b0; goodColl = 1'b0;
    run(42);

    cur_tag = "bad";
    badColl = 1'b1; playSound = 1'b1;
    plan_idle(1); plan_note(SND_BAD, 3, 40); plan_gap(8); plan_note(SND_BAD, 6, 40);
    run(1);
    playSound = 1'b0; badColl = 1'b0;
    run(90);

    cur_tag = "move_good_ignored";
    direction = 4'b0001; playSound = 1'b1;
    plan_idle(1); plan_note(SND_MOVE, 2, 10);
    run(1);
    playSound = 1'b0; direction = 4'b0000;
    run(5);
    playSound = 1'b1; goodColl = 1'b1;
    run(1);
    playSound = 1'b0; goodColl = 1'b0;
    run(7);

    cur_tag = "move_bad_preempt";
    direction = 4'b0001; playSound = 1'b1;
    plan_idle(1); plan_note(SND_MOVE, 2, 6);
    plan_note(SND_BAD, 3, 40); plan_gap(8); plan_note(SND_BAD, 6, 40);
    run(1);
    playSound = 1'b0; direction = 4'b0000;
    run(5);
    playSound = 1'b1; badColl = 1'b1;
    run(1);
    playSound = 1'b0; badColl = 1'b0;
    run(90);

    cur_tag = "mute";
    goodColl = 1'b1; playSound = 1'b1;
    plan_idle(1); plan_note(SND_GOOD, 4, 21);
    run(1);
    playSound = 1'b0; goodColl = 1'b0;
    run(20);
    mode_i = 1'b0;
    run(3);

    cur_tag = "trig_muted";
    playSound = 1'b1; goodColl = 1'b1;
    run(4);
    playSound = 1'b0; goodColl = 1'b0; mode_i = 1'b1;
    run(2);

    cur_tag = "no_source";
    playSound = 1'b1;
    run(4);
    playSound = 1'b0;
    run(2);

    cur_tag = "reset_mid";
    goodColl = 1'b1; playSound = 1'b1;
    plan_idle(1); plan_note(SND_GOOD, 4, 10);
    run(1);
    playSound = 1'b0; goodColl = 1'b0;
    run(10);
    rst = 1'b1;
    plan.delete();
    run(2);
    rst = 1'b0;
    run(3);

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
